sha256_compress_core: RTL and testbench
=======================================

SHA256_COMPRESS_CORE -- requirements
Module: sha256_compress_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, giving rounds per accepted word beat; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter ENABLE_224, default 1; when 1, SHA-224 mode is supported; when 0, mode_224 is ignored and treated as 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port blk_valid, input, 1 bit: request to start compressing a 512-bit block.
REQ-006 SHALL have port blk_ready, output, 1 bit: core is idle and accepts blk_valid.
REQ-007 SHALL have port blk_first, input, 1 bit: 1 loads the IV; 0 chains from the previous digest.
REQ-008 SHALL have port mode_224, input, 1 bit: 1 selects SHA-224 IV and output truncation; sampled only on a first-block accept.
REQ-009 SHALL have port w_valid, input, 1 bit: w_data holds ROUNDS_PER_CYCLE scheduled words.
REQ-010 SHALL have port w_ready, output, 1 bit: core consumes w_data this cycle.
REQ-011 SHALL have port w_data, input, 32*ROUNDS_PER_CYCLE bits: lane i (bits 32i+31:32i) is W[t+i].
REQ-012 SHALL have port dig_valid, output, 1 bit: digest is valid.
REQ-013 SHALL have port dig_ready, input, 1 bit: consumer accepts the digest.
REQ-014 SHALL have port digest, output, 256 bits: H0 is at bits 255:224, H7 at bits 31:0.
REQ-015 SHALL have port round_idx, output, 7 bits: number of rounds completed in the current block (0..64).

Function
REQ-016 SHALL implement an FSM with states IDLE, ROUND, FINAL and HOLD.
REQ-017 IDLE: blk_ready=1, w_ready=0, dig_valid=0; a blk_valid&blk_ready handshake moves the FSM to ROUND and clears round_idx.
REQ-018 On accept with blk_first=1, or with chain_valid=0: chain and working regs a..h are loaded with the IV for the latched mode, and chain_valid is set.
REQ-019 On accept with blk_first=0 and chain_valid=1: working regs load from chain; the latched mode is kept and mode_224 is ignored.
REQ-020 SHA-256 IV SHALL be 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
REQ-021 SHA-224 IV SHALL be c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
REQ-022 ROUND: w_ready=1; each w_valid&w_ready cycle applies ROUNDS_PER_CYCLE FIPS 180-4 rounds, sequentially within the cycle, using K[round_idx+i] and lane i, then adds ROUNDS_PER_CYCLE to round_idx.
REQ-023 w_valid=0 in ROUND SHALL stall the core: working regs and round_idx hold, with no timeout.
REQ-024 When round_idx reaches 64, the FSM moves to FINAL and w_ready drops the same cycle; no extra word is consumed.
REQ-025 FINAL (1 cycle): chain[j] <= chain[j] + working[j], each mod 2^32 with carries discarded; then the FSM moves to HOLD.
REQ-026 HOLD: dig_valid=1 and digest=chain; in SHA-224 mode, bits 31:0 are driven 0.
REQ-027 digest SHALL stay stable while dig_valid=1 and dig_ready=0.
REQ-028 dig_valid&dig_ready moves the FSM to IDLE; a blk_valid in that same cycle is not accepted (blk_ready=0).
REQ-029 Latency from block accept to dig_valid, with w_valid held high, SHALL be 64/ROUNDS_PER_CYCLE+1 cycles; each additional stall cycle adds one.
REQ-030 blk_valid outside IDLE, and w_valid outside ROUND, SHALL be ignored.
REQ-031 All rounds SHALL use the FIPS 180-4 functions Ch, Maj, Σ0 and Σ1 with mod-2^32 addition.

Reset
REQ-032 reset_n=0 SHALL asynchronously force: FSM=IDLE, round_idx=0, chain=0, working regs=0, chain_valid=0, mode latch=0, dig_valid=0, w_ready=0, digest=0.
REQ-033 blk_ready SHALL be 1 while in reset and after reset.
REQ-034 Reset asserted mid-block or in HOLD SHALL abandon the operation; the next block is treated as first regardless of blk_first.
REQ-035 Reset SHALL be deasserted synchronously to clk externally; the core adds no synchronizer.

Verification
REQ-036 SHA-256 "abc", single padded block, blk_first=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-037 SHA-224 "abc", mode_224=1 -> digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
REQ-038 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first=1, then first=0) -> final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-039 Empty message, ROUNDS_PER_CYCLE=4, random w_valid stalls and dig_ready backpressure -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, unchanged during backpressure; with no stalls, dig_valid 17 cycles after accept.
REQ-040 Reset pulsed at round_idx=30, then the "abc" block issued with blk_first=0 -> IV is used and the digest equals REQ-036; exactly 64/ROUNDS_PER_CYCLE words are consumed per block.

Source files
------------

// File: rtl/sha256_compress_core.sv
// SHA-256 / SHA-224 compression core: consumes pre-scheduled words W[t] and
// applies ROUNDS_PER_CYCLE FIPS 180-4 rounds per accepted word beat.
module sha256_compress_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int ENABLE_224       = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          blk_valid,
    output logic                          blk_ready,
    input  logic                          blk_first,
    input  logic                          mode_224,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [32*ROUNDS_PER_CYCLE-1:0] w_data,
    output logic                          dig_valid,
    input  logic                          dig_ready,
    output logic [255:0]                  digest,
    output logic [6:0]                    round_idx,
    output logic [1:0]                    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both 1; ready outputs depend only on the FSM state, never on valid.
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, HOLD = 2'd3} state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] IV224 [0:7] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  round_idx_q, round_idx_d;
    logic [31:0] chain_q [0:7];
    logic [31:0] chain_d [0:7];
    logic [31:0] work_q  [0:7];
    logic [31:0] work_d  [0:7];
    logic [31:0] rnd     [0:7];
    logic        chain_valid_q, chain_valid_d;
    logic        mode_q, mode_d;
    logic        mode_eff;
    logic [31:0] t1, t2;
    logic [5:0]  k_idx;

    assign mode_eff = (ENABLE_224 != 0) && mode_224;

    always_comb begin
        state_d       = state_q;
        round_idx_d   = round_idx_q;
        chain_d       = chain_q;
        work_d        = work_q;
        chain_valid_d = chain_valid_q;
        mode_d        = mode_q;
        blk_ready     = 1'b0;
        w_ready       = 1'b0;
        dig_valid     = 1'b0;
        t1            = '0;
        t2            = '0;
        k_idx         = '0;

        // Rounds are chained combinationally so one beat covers all lanes.
        rnd = work_q;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            k_idx  = round_idx_q[5:0] + 6'(i);
            t1     = rnd[7] + bsig1(rnd[4]) + ((rnd[4] & rnd[5]) ^ (~rnd[4] & rnd[6]))
                   + K[k_idx] + w_data[32*i +: 32];
            t2     = bsig0(rnd[0]) + ((rnd[0] & rnd[1]) ^ (rnd[0] & rnd[2]) ^ (rnd[1] & rnd[2]));
            rnd[7] = rnd[6];
            rnd[6] = rnd[5];
            rnd[5] = rnd[4];
            rnd[4] = rnd[3] + t1;
            rnd[3] = rnd[2];
            rnd[2] = rnd[1];
            rnd[1] = rnd[0];
            rnd[0] = t1 + t2;
        end

        case (state_q)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    state_d     = ROUND;
                    round_idx_d = '0;
                    if (blk_first || !chain_valid_q) begin
                        mode_d        = mode_eff;
                        chain_valid_d = 1'b1;
                        chain_d       = mode_eff ? IV224 : IV256;
                        work_d        = mode_eff ? IV224 : IV256;
                    end else begin
                        work_d = chain_q;
                    end
                end
            end
            ROUND: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    work_d      = rnd;
                    round_idx_d = round_idx_q + 7'(ROUNDS_PER_CYCLE);
                    if (round_idx_d == 7'd64) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                for (int j = 0; j < 8; j++) begin
                    chain_d[j] = chain_q[j] + work_q[j];
                end
                state_d = HOLD;
            end
            HOLD: begin
                dig_valid = 1'b1;
                if (dig_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            round_idx_q   <= '0;
            chain_valid_q <= 1'b0;
            mode_q        <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                chain_q[j] <= '0;
                work_q[j]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            round_idx_q   <= round_idx_d;
            chain_valid_q <= chain_valid_d;
            mode_q        <= mode_d;
            for (int j = 0; j < 8; j++) begin
                chain_q[j] <= chain_d[j];
                work_q[j]  <= work_d[j];
            end
        end
    end

    // SHA-224 exposes only H0..H6; the H7 slot reads as zero.
    assign digest    = {chain_q[0], chain_q[1], chain_q[2], chain_q[3],
                        chain_q[4], chain_q[5], chain_q[6], mode_q ? 32'h0 : chain_q[7]};
    assign round_idx = round_idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed bench for sha256_compress_core: instance 0 runs one round per beat,
// instance 1 runs four rounds per beat with SHA-224 support disabled.
module tb_sha256_compress_core;

    localparam logic [255:0] DIG_ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] DIG_TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] DIG_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic         blk_valid [2];
    logic         blk_first [2];
    logic         mode_224  [2];
    logic         w_valid   [2];
    logic         dig_ready [2];
    logic [127:0] w_data    [2];
    logic         blk_ready [2];
    logic         w_ready   [2];
    logic         dig_valid [2];
    logic [255:0] digest    [2];
    logic [6:0]   round_idx [2];
    logic [1:0]   dbg_state [2];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] msg   [16];
    logic [31:0] sched [64];

    sha256_compress_core #(.ROUNDS_PER_CYCLE(1), .ENABLE_224(1)) u_r1 (
        .clk(clk), .reset_n(reset_n),
        .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]), .blk_first(blk_first[0]),
        .mode_224(mode_224[0]), .w_valid(w_valid[0]), .w_ready(w_ready[0]),
        .w_data(w_data[0][31:0]), .dig_valid(dig_valid[0]), .dig_ready(dig_ready[0]),
        .digest(digest[0]), .round_idx(round_idx[0]), .dbg_state(dbg_state[0])
    );

    sha256_compress_core #(.ROUNDS_PER_CYCLE(4), .ENABLE_224(0)) u_r4 (
        .clk(clk), .reset_n(reset_n),
        .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]), .blk_first(blk_first[1]),
        .mode_224(mode_224[1]), .w_valid(w_valid[1]), .w_ready(w_ready[1]),
        .w_data(w_data[1]), .dig_valid(dig_valid[1]), .dig_ready(dig_ready[1]),
        .digest(digest[1]), .round_idx(round_idx[1]), .dbg_state(dbg_state[1])
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Padded message blocks: 0 = "abc", 1 = empty, 2/3 = two-block "abcdbcde..." message.
    task automatic load_msg(input int which);
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        case (which)
            0: begin msg[0] = 32'h61626380; msg[15] = 32'h00000018; end
            1: msg[0] = 32'h80000000;
            2: begin
                for (int i = 0; i < 14; i++) begin
                    msg[i] = {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
                end
                msg[14] = 32'h80000000;
            end
            default: msg[15] = 32'h000001c0;
        endcase
        for (int t = 0; t < 16; t++) sched[t] = msg[t];
        for (int t = 16; t < 64; t++) begin
            sched[t] = sched[t-16] + sched[t-7]
                     + (rotr(sched[t-15], 7) ^ rotr(sched[t-15], 18) ^ (sched[t-15] >> 3))
                     + (rotr(sched[t-2], 17) ^ rotr(sched[t-2], 19) ^ (sched[t-2] >> 10));
        end
    endtask

    task automatic drive_words(input int inst, input int t);
        int rpc;
        rpc = (inst == 0) ? 1 : 4;
        w_data[inst] = '0;
        for (int i = 0; i < rpc; i++) begin
            if (t + i < 64) w_data[inst][32*i +: 32] = sched[t + i];
        end
    endtask

    // Runs one block end to end on instance inst and checks digest, word count,
    // round progress, latency (optional), hold stability and the exit handshake.
    task automatic run_block(input int inst, input bit first, input bit mode, input int stall_pct,
                             input int bp_max, input logic [255:0] exp_dig, input string name,
                             input bit check_lat);
        int rpc, guard, lat, t, beats, n_bp;
        bit hs, done;
        rpc = (inst == 0) ? 1 : 4;
        @(negedge clk);
        blk_valid[inst] = 1'b1;
        blk_first[inst] = first;
        mode_224[inst]  = mode;
        guard = 0;
        while (blk_ready[inst] !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 100) begin
            n_err++;
            $display("FAIL %s accept: blk_ready=%b never rose, want 1", name, blk_ready[inst]);
        end
        @(posedge clk);
        lat = 0; t = 0; beats = 0; done = 1'b0;
        while (lat < 2000 && !done) begin
            @(negedge clk);
            blk_valid[inst] = 1'b0;
            mode_224[inst]  = ~mode;
            if (dig_valid[inst] === 1'b1) begin
                done = 1'b1;
            end else begin
                if (w_ready[inst] === 1'b1) begin
                    n_cmp++;
                    if (round_idx[inst] !== 7'(t)) begin
                        n_err++;
                        $display("FAIL %s round_idx: got %0d want %0d", name, round_idx[inst], t);
                    end
                end
                w_valid[inst] = ($urandom_range(99) >= stall_pct);
                drive_words(inst, t);
                hs = w_valid[inst] && w_ready[inst];
                @(posedge clk);
                lat++;
                if (hs) begin
                    t += rpc;
                    beats++;
                end
            end
        end
        w_valid[inst] = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s timeout: dig_valid=%b after %0d cycles, want 1", name, dig_valid[inst], lat);
        end
        n_cmp++;
        if (beats !== 64 / rpc) begin
            n_err++;
            $display("FAIL %s beats: got %0d want %0d", name, beats, 64 / rpc);
        end
        n_cmp++;
        if (round_idx[inst] !== 7'd64) begin
            n_err++;
            $display("FAIL %s final_round_idx: got %0d want 64", name, round_idx[inst]);
        end
        if (check_lat) begin
            n_cmp++;
            if (lat !== 64 / rpc + 1) begin
                n_err++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, 64 / rpc + 1);
            end
        end
        n_bp = $urandom_range(bp_max);
        for (int k = 0; k <= n_bp; k++) begin
            if (k > 0) @(negedge clk);
            n_cmp++;
            if (digest[inst] !== exp_dig || dig_valid[inst] !== 1'b1) begin
                n_err++;
                $display("FAIL %s digest(hold %0d): valid=%b got %h want %h", name, k,
                         dig_valid[inst], digest[inst], exp_dig);
            end
        end
        dig_ready[inst] = 1'b1;
        blk_valid[inst] = 1'b1;
        n_cmp++;
        if (blk_ready[inst] !== 1'b0) begin
            n_err++;
            $display("FAIL %s blk_ready_in_hold: got %b want 0", name, blk_ready[inst]);
        end
        @(posedge clk);
        @(negedge clk);
        dig_ready[inst] = 1'b0;
        blk_valid[inst] = 1'b0;
        n_cmp++;
        if (dig_valid[inst] !== 1'b0 || blk_ready[inst] !== 1'b1 || w_ready[inst] !== 1'b0) begin
            n_err++;
            $display("FAIL %s exit_idle: dig_valid=%b blk_ready=%b w_ready=%b want 0 1 0", name,
                     dig_valid[inst], blk_ready[inst], w_ready[inst]);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        for (int inst = 0; inst < 2; inst++) begin
            n_cmp++;
            if (blk_ready[inst] !== 1'b1 || w_ready[inst] !== 1'b0 || dig_valid[inst] !== 1'b0 ||
                digest[inst] !== 256'h0 || round_idx[inst] !== 7'd0) begin
                n_err++;
                $display("FAIL %s inst%0d: blk_ready=%b w_ready=%b dig_valid=%b round_idx=%0d digest=%h want 1 0 0 0 0",
                         name, inst, blk_ready[inst], w_ready[inst], dig_valid[inst], round_idx[inst], digest[inst]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int inst = 0; inst < 2; inst++) begin
            blk_valid[inst] = 1'b0; blk_first[inst] = 1'b0; mode_224[inst] = 1'b0;
            w_valid[inst] = 1'b0; dig_ready[inst] = 1'b0; w_data[inst] = '0;
        end
        #1;
        check_idle_outputs("reset_during");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        // Words offered while idle must not advance anything.
        w_valid[0] = 1'b1; w_valid[1] = 1'b1;
        w_data[0] = 128'h1234; w_data[1] = {4{32'hdeadbeef}};
        repeat (4) @(negedge clk);
        w_valid[0] = 1'b0; w_valid[1] = 1'b0;
        check_idle_outputs("reset_after");
    endtask

    task automatic test_abc_256();
        load_msg(0);
        run_block(0, 1'b1, 1'b0, 0, 3, DIG_ABC256, "abc256", 1'b1);
    endtask

    task automatic test_abc_224();
        load_msg(0);
        run_block(0, 1'b1, 1'b1, 0, 3, DIG_ABC224, "abc224", 1'b1);
    endtask

    task automatic test_two_block();
        load_msg(2);
        run_block(0, 1'b1, 1'b0, 20, 2, 256'h0, "two_blk1_skip", 1'b0);
    endtask

    task automatic test_back_to_back();
        load_msg(3);
        // Chained block: mode_224=1 here must be ignored.
        run_block(0, 1'b0, 1'b1, 30, 4, DIG_TWO, "two_blk2", 1'b0);
    endtask

    task automatic test_empty_rpc4();
        load_msg(1);
        run_block(1, 1'b1, 1'b0, 0, 0, DIG_EMPTY, "empty_r4_nostall", 1'b1);
        run_block(1, 1'b1, 1'b1, 40, 8, DIG_EMPTY, "empty_r4_stall_no224", 1'b0);
    endtask

    task automatic test_reset_mid_block();
        int guard;
        load_msg(1);
        @(negedge clk);
        blk_valid[0] = 1'b1; blk_first[0] = 1'b1; mode_224[0] = 1'b1;
        @(negedge clk);
        blk_valid[0] = 1'b0;
        w_valid[0] = 1'b1;
        guard = 0;
        while (round_idx[0] !== 7'd30 && guard < 200) begin
            drive_words(0, int'(round_idx[0]));
            @(negedge clk);
            guard++;
        end
        w_valid[0] = 1'b0;
        n_cmp++;
        if (guard >= 200) begin
            n_err++;
            $display("FAIL reset_mid reach30: round_idx=%0d want 30", round_idx[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        load_msg(0);
        run_block(0, 1'b0, 1'b0, 0, 2, DIG_ABC256, "abc_after_reset", 1'b1);
    endtask

    // The two-block case compares only the final digest; the intermediate one
    // is still run through run_block, so its hold check is kept meaningful by
    // using the known first-block chaining value here.
    initial begin
        test_reset();
        test_abc_256();
        test_abc_224();
        load_msg(2);
        run_block(0, 1'b1, 1'b0, 20, 2,
                  256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a,
                  "two_blk1", 1'b0);
        test_back_to_back();
        test_empty_rpc4();
        test_reset_mid_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
